// File: rtl/spi_fifo_tx.sv
// spi_fifo_tx: buffered, write-only SPI (mode 0) transmitter for the TFT panel.
// Words {dc, payload} are queued in a FIFO and shifted out MSB-first.
// SCK half-period is CLK_DIV spiClk cycles.
//
// Ports:
//   spiClk        system clock, rising edge
//   reset         asynchronous active-high reset
//   data          [DATA_WIDTH] = dc, [DATA_WIDTH-1:0] = payload
//   dataAvailable write strobe, one word per cycle
//   full          FIFO full (writes while full are dropped)
//   overflow      sticky dropped-write flag, cleared by reset only
//   tft_sck/sdi/dc/cs  panel pins (cs active low, sck idles low)
//   idle          FIFO empty, FSM idle, cs high
//
// Optional feature macro: SPI_TX_BURST_CS_EN keeps tft_cs low across
// back-to-back words when the FIFO still holds data at word completion.
module spi_fifo_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                spiClk,
  input  logic                reset,
  input  logic [DATA_WIDTH:0] data,
  input  logic                dataAvailable,
  output logic                full,
  output logic                overflow,
  output logic                tft_sck,
  output logic                tft_sdi,
  output logic                tft_dc,
  output logic                tft_cs,
  output logic                idle
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DVW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e                state_q;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DVW-1:0]        div_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  sck_q, sdi_q, dc_q, cs_q, idle_q, ovf_q;

  logic                  empty, push, pop, div_done, word_done, to_idle;
  logic [DATA_WIDTH:0]   head;

  assign full = (count_q == DEPTH_C);

  always_comb begin
    empty     = (count_q == '0);
    push      = dataAvailable & ~full;
    div_done  = (div_q == DIV_LAST);
    word_done = (state_q == S_SHIFT) & div_done & sck_q & (bit_q == BIT_LAST);
    head      = mem_q[rptr_q];
    pop       = 1'b0;
    to_idle   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop     = ~empty;
        to_idle = empty;
      end
      // The pop normally done in IDLE is taken at the GAP terminal edge,
      // so cs-high between framed words is exactly CLK_DIV cycles.
      S_GAP: begin
        if (div_done) begin
          pop     = ~empty;
          to_idle = empty;
        end
      end
`ifdef SPI_TX_BURST_CS_EN
      S_SHIFT: pop = word_done & ~empty;
`endif
      default: ;
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge spiClk) begin
    if (push) mem_q[wptr_q] <= data;
  end

  always_ff @(posedge spiClk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge spiClk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
      idle_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (dataAvailable && full) ovf_q <= 1'b1;
      idle_q <= to_idle && (count_d == '0);
      if (pop) begin
        state_q <= S_SHIFT;
        cs_q    <= 1'b0;
        sck_q   <= 1'b0;
        dc_q    <= head[DATA_WIDTH];
        sdi_q   <= head[DATA_WIDTH-1];
        shift_q <= {head[DATA_WIDTH-2:0], 1'b0};
        div_q   <= '0;
        bit_q   <= '0;
      end else begin
        case (state_q)
          S_SHIFT: begin
            if (div_done) begin
              div_q <= '0;
              sck_q <= ~sck_q;
              // Data only moves on the falling SCK edge.
              if (sck_q) begin
                if (word_done) begin
                  state_q <= S_HOLD;
                end else begin
                  bit_q   <= bit_q + BW'(1);
                  sdi_q   <= shift_q[DATA_WIDTH-1];
                  shift_q <= shift_q << 1;
                end
              end
            end else begin
              div_q <= div_q + DVW'(1);
            end
          end
          S_HOLD: begin
            if (div_done) begin
              div_q   <= '0;
              cs_q    <= 1'b1;
              state_q <= S_GAP;
            end else begin
              div_q <= div_q + DVW'(1);
            end
          end
          S_GAP: begin
            if (div_done) begin
              div_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              div_q <= div_q + DVW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign overflow = ovf_q;
  assign tft_sck  = sck_q;
  assign tft_sdi  = sdi_q;
  assign tft_dc   = dc_q;
  assign tft_cs   = cs_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_spi_fifo_tx.sv
module tb_spi_fifo_tx;

`ifdef SPI_TX_BURST_CS_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: DATA_WIDTH=8, FIFO_DEPTH=4, CLK_DIV=2
  logic [8:0] d1;
  logic av1, full1, ovf1, sck1, sdi1, dc1, cs1, idle1;
  spi_fifo_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(2)) u1 (
    .spiClk(clk), .reset(rst), .data(d1), .dataAvailable(av1),
    .full(full1), .overflow(ovf1), .tft_sck(sck1), .tft_sdi(sdi1),
    .tft_dc(dc1), .tft_cs(cs1), .idle(idle1));

  // Second instance: DATA_WIDTH=16, FIFO_DEPTH=4, CLK_DIV=1
  logic [16:0] d2;
  logic av2, full2, ovf2, sck2, sdi2, dc2, cs2, idle2;
  spi_fifo_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CLK_DIV(1)) u2 (
    .spiClk(clk), .reset(rst), .data(d2), .dataAvailable(av2),
    .full(full2), .overflow(ovf2), .tft_sck(sck2), .tft_sdi(sdi2),
    .tft_dc(dc2), .tft_cs(cs2), .idle(idle2));

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  logic [8:0]  mon_q[$];
  logic [16:0] mon2_q[$];

  // Panel model for u1: samples sdi on rising SCK while cs is low,
  // and measures cs-high gaps between frames.
  int nb1 = 0, gap_run = 0, last_gap = 0, n_gaps = 0;
  bit seen_low = 1'b0, sp1 = 1'b0;
  logic [7:0] sh1 = '0;
  always @(negedge clk) begin
    if (cs1 !== 1'b0) begin
      nb1 = 0;
      if (seen_low) gap_run++;
    end else begin
      if (gap_run > 0) begin
        last_gap = gap_run;
        n_gaps++;
      end
      gap_run  = 0;
      seen_low = 1'b1;
      if (sck1 === 1'b1 && !sp1) begin
        sh1 = {sh1[6:0], sdi1};
        nb1++;
        if (nb1 == 8) begin
          mon_q.push_back({dc1, sh1});
          nb1 = 0;
        end
      end
    end
    sp1 = (sck1 === 1'b1);
  end

  // Panel model for u2.
  int nb2 = 0;
  bit sp2 = 1'b0;
  logic [15:0] sh2 = '0;
  always @(negedge clk) begin
    if (cs2 !== 1'b0) begin
      nb2 = 0;
    end else if (sck2 === 1'b1 && !sp2) begin
      sh2 = {sh2[14:0], sdi2};
      nb2++;
      if (nb2 == 16) begin
        mon2_q.push_back({dc2, sh2});
        nb2 = 0;
      end
    end
    sp2 = (sck2 === 1'b1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] w, input bit keep);
    d1  = w;
    av1 = 1'b1;
    tick();
    av1 = 1'b0;
    if (keep) exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (idle1 !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk1(tag, idle1, 1'b1);
  endtask

  task automatic chk_words(input string tag);
    chkw({tag, "_nwords"}, mon_q.size(), exp_q.size());
    while (mon_q.size() > 0 && exp_q.size() > 0)
      chkw(tag, int'(mon_q.pop_front()), int'(exp_q.pop_front()));
    mon_q.delete();
    exp_q.delete();
  endtask

  logic [8:0] t2w [6] = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h166};

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    int rises;
    int unsigned n;
    bit prev, act;
    logic [8:0] w;

    rst = 1'b1; av1 = 1'b0; d1 = '0; av2 = 1'b0; d2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk1("rst_cs", cs1, 1'b1);
    chk1("rst_sck", sck1, 1'b0);
    chk1("rst_sdi", sdi1, 1'b0);
    chk1("rst_dc", dc1, 1'b0);
    chk1("rst_idle", idle1, 1'b1);
    chk1("rst_full", full1, 1'b0);
    chk1("rst_ovf", ovf1, 1'b0);

    // T1 single word
    wr(9'h1A5, 1'b1);
    chk1("t1_idle_wr", idle1, 1'b0);
    chk1("t1_cs_wr", cs1, 1'b1);
    tick();                                   // pop edge P
    chk1("t1_cs_pop", cs1, 1'b0);
    chk1("t1_dc", dc1, 1'b1);
    chk1("t1_sdi_msb", sdi1, 1'b1);
    chk1("t1_sck_pop", sck1, 1'b0);
    tick(); tick();                           // P+2
    chk1("t1_sck_rise", sck1, 1'b1);
    repeat (31) tick();                       // P+33
    chk1("t1_cs_p33", cs1, 1'b0);
    tick();                                   // P+34
    chk1("t1_cs_p34", cs1, 1'b1);
    chk1("t1_idle_p34", idle1, 1'b0);
    tick();
    chk1("t1_idle_p35", idle1, 1'b0);
    tick();
    chk1("t1_idle_p36", idle1, 1'b1);
    chk_words("t1_word");

    // T2 fill / overflow
    for (int unsigned i = 0; i < 6; i++) begin
      wr(t2w[i], i < 5);
      if (i == 3) chk1("t2_full_4th", full1, 1'b0);
      if (i == 4) begin
        chk1("t2_full_5th", full1, 1'b1);
        chk1("t2_ovf_5th", ovf1, 1'b0);
      end
    end
    chk1("t2_ovf_6th", ovf1, 1'b1);
    chk1("t2_full_6th", full1, 1'b1);
    g0 = n_gaps;
    wait_idle("t2_drain");
    chk1("t2_ovf_sticky", ovf1, 1'b1);
    chk1("t2_full_end", full1, 1'b0);
    chkw("t2_gaps", n_gaps - g0, BURST ? 0 : 4);
`ifndef SPI_TX_BURST_CS_EN
    chkw("t2_gap_len", last_gap, 2);
`endif
    chk_words("t2_word");

    // T3 back-to-back pair
    wr(9'h0FF, 1'b1);
    wr(9'h100, 1'b1);
    tick(); tick();
    g0 = n_gaps;
    wait_idle("t3_drain");
    chkw("t3_gaps", n_gaps - g0, BURST ? 0 : 1);
`ifndef SPI_TX_BURST_CS_EN
    chkw("t3_gap_len", last_gap, 2);
`endif
    chk_words("t3_word");

    // T4 reset mid-word
    chk1("t4_ovf_pre", ovf1, 1'b1);
    wr(9'h055, 1'b0);
    rises = 0; n = 0; prev = sck1;
    while (rises < 3 && n < 200) begin
      tick();
      if (sck1 === 1'b1 && !prev) rises++;
      prev = (sck1 === 1'b1);
      n++;
    end
    chkw("t4_rises", rises, 3);
    rst = 1'b1;
    #1;
    chk1("t4_cs", cs1, 1'b1);
    chk1("t4_sck", sck1, 1'b0);
    chk1("t4_sdi", sdi1, 1'b0);
    chk1("t4_idle", idle1, 1'b1);
    chk1("t4_full", full1, 1'b0);
    chk1("t4_ovf", ovf1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    act = 1'b0;
    repeat (60) begin
      tick();
      if (cs1 !== 1'b1 || sck1 !== 1'b0 || idle1 !== 1'b1) act = 1'b1;
    end
    chk1("t4_quiet", act, 1'b0);
    chk_words("t4_word");

    // T6 pointer wrap: three fill/drain rounds
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned i = 0; i < 5; i++) begin
        w = 9'(r * 97 + i * 29 + 5);
        wr(w, 1'b1);
        if (i == 0) chk1("t6_idle_wr", idle1, 1'b0);
        if (i == 3) chk1("t6_full_lo", full1, 1'b0);
        if (i == 4) chk1("t6_full_hi", full1, 1'b1);
      end
      wait_idle("t6_drain");
      chk1("t6_full_end", full1, 1'b0);
      chk_words("t6_word");
    end
    chk1("t6_ovf", ovf1, 1'b0);

    // T5 CLK_DIV=1, DATA_WIDTH=16
    d2 = 17'h0_8001;
    av2 = 1'b1;
    tick();
    av2 = 1'b0;
    chk1("t5_idle_wr", idle2, 1'b0);
    tick();                                   // pop
    chk1("t5_cs", cs2, 1'b0);
    chk1("t5_dc", dc2, 1'b0);
    chk1("t5_sdi_msb", sdi2, 1'b1);
    chk1("t5_sck0", sck2, 1'b0);
    tick();
    chk1("t5_sck1", sck2, 1'b1);
    tick();
    chk1("t5_sck2", sck2, 1'b0);
    chk1("t5_sdi_b1", sdi2, 1'b0);
    n = 0;
    while (idle2 !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk1("t5_drain", idle2, 1'b1);
    chkw("t5_nwords", mon2_q.size(), 1);
    if (mon2_q.size() > 0) chkw("t5_word", int'(mon2_q.pop_front()), 32'h0_8001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
